// File: rtl/counter_updown_param_if.sv
// Control and status bundle for counter_updown_param; the master drives controls, the slave is the counter.
// Purely structural: no latency, no backpressure.
interface counter_updown_param_if #(
    parameter int P_WIDTH = 8
) ();
    logic               clear;
    logic               load;
    logic [P_WIDTH-1:0] load_data;
    logic               enable;
    logic               up_down;
    logic [1:0]         mode;
    logic [P_WIDTH-1:0] count;
    logic               counter_is_max;
    logic               counter_is_min;
    logic               tc_pulse;
    logic               done;

    modport master (
        output clear, load, load_data, enable, up_down, mode,
        input  count, counter_is_max, counter_is_min, tc_pulse, done
    );

    modport slave (
        input  clear, load, load_data, enable, up_down, mode,
        output count, counter_is_max, counter_is_min, tc_pulse, done
    );
endinterface

// File: rtl/counter_updown_param.sv
// Windowed up/down counter with prescaler, wrap/saturate/one-shot modes; count/tc_pulse/done update one edge after the input.
// No backpressure: controls are honoured every cycle with priority clear > load > step.
module counter_updown_param #(
    parameter int P_WIDTH     = 8,
    parameter int P_COUNT_MIN = 0,
    parameter int P_COUNT_MAX = 200,
    parameter int P_PRESCALE  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_updown_param_if.slave  bus
);
    localparam int PS_W = (P_PRESCALE > 1) ? $clog2(P_PRESCALE) : 1;
    localparam logic [P_WIDTH-1:0] CNT_MIN = P_WIDTH'(P_COUNT_MIN);
    localparam logic [P_WIDTH-1:0] CNT_MAX = P_WIDTH'(P_COUNT_MAX);
    localparam logic [PS_W-1:0]    PS_LAST = PS_W'(P_PRESCALE - 1);

    if (P_WIDTH < 2 || P_WIDTH > 16) begin : g_bad_width
        $error("counter_updown_param: P_WIDTH must be 2..16");
    end
    if (P_COUNT_MIN < 0 || P_COUNT_MIN >= P_COUNT_MAX) begin : g_bad_window
        $error("counter_updown_param: need 0 <= P_COUNT_MIN < P_COUNT_MAX");
    end
    if (P_COUNT_MAX > (1 << P_WIDTH) - 1) begin : g_bad_max
        $error("counter_updown_param: P_COUNT_MAX exceeds counter width");
    end
    if (P_PRESCALE < 1 || P_PRESCALE > 256) begin : g_bad_prescale
        $error("counter_updown_param: P_PRESCALE must be 1..256");
    end

    typedef enum logic {ST_RUN, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] count_q, count_d;
    logic [PS_W-1:0]    ps_q, ps_d;
    logic               tc_q, tc_d;
    logic               step_evt;
    logic               at_bound;
    logic               above_max, below_min;

    // Clamp compares are dropped when the window edge coincides with the range edge (they would be constant).
    if (P_COUNT_MAX == (1 << P_WIDTH) - 1) begin : g_no_hi_clamp
        assign above_max = 1'b0;
    end else begin : g_hi_clamp
        assign above_max = bus.load_data > CNT_MAX;
    end
    if (P_COUNT_MIN == 0) begin : g_no_lo_clamp
        assign below_min = 1'b0;
    end else begin : g_lo_clamp
        assign below_min = bus.load_data < CNT_MIN;
    end

    always_comb begin
        count_d  = count_q;
        ps_d     = ps_q;
        tc_d     = 1'b0;
        state_d  = state_q;
        step_evt = 1'b0;
        at_bound = bus.up_down ? (count_q == CNT_MAX) : (count_q == CNT_MIN);

        if (bus.clear) begin
            count_d = CNT_MIN;
            ps_d    = '0;
            state_d = ST_RUN;
        end else if (bus.load) begin
            count_d = above_max ? CNT_MAX : (below_min ? CNT_MIN : bus.load_data);
            ps_d    = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && bus.enable) begin
            if (ps_q == PS_LAST) begin
                ps_d     = '0;
                step_evt = 1'b1;
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end

        if (step_evt) begin
            if (!at_bound) begin
                count_d = bus.up_down ? count_q + 1'b1 : count_q - 1'b1;
            end else begin
                tc_d = 1'b1;
                case (bus.mode)
                    2'b01: begin
                        count_d = count_q;
                    end
                    2'b10: begin
                        state_d = ST_DONE;
                    end
                    default: begin
                        count_d = bus.up_down ? CNT_MIN : CNT_MAX;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CNT_MIN;
            ps_q    <= '0;
            tc_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign bus.count          = count_q;
    assign bus.counter_is_max = (count_q == CNT_MAX);
    assign bus.counter_is_min = (count_q == CNT_MIN);
    assign bus.tc_pulse       = tc_q;
    assign bus.done           = (state_q == ST_DONE);
endmodule

// File: tb/tb_counter_updown_param.sv
// Scoreboard bench: two counters (window 2..10, prescale 1 and 3) driven by directed vectors.
module tb_counter_updown_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_updown_param_if #(.P_WIDTH(4)) ifa ();
    counter_updown_param_if #(.P_WIDTH(4)) ifb ();

    counter_updown_param #(.P_WIDTH(4), .P_COUNT_MIN(2), .P_COUNT_MAX(10), .P_PRESCALE(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    counter_updown_param #(.P_WIDTH(4), .P_COUNT_MIN(2), .P_COUNT_MAX(10), .P_PRESCALE(3))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        bit    sel;
        int    cnt;
        bit    tc;
        bit    dn;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // One cycle of stimulus: drive at negedge, queue what the DUT must show after the next posedge.
    task automatic tick(input bit sel, input bit clr, input bit ld, input int d, input bit en,
                        input bit ud, input int md, input int ec, input bit etc, input bit edn,
                        input string nm);
        exp_t e;
        @(negedge clk);
        if (!sel) begin
            ifa.clear = clr; ifa.load = ld; ifa.load_data = 4'(d);
            ifa.enable = en; ifa.up_down = ud; ifa.mode = 2'(md);
            ifb.clear = 1'b0; ifb.load = 1'b0; ifb.enable = 1'b0;
        end else begin
            ifb.clear = clr; ifb.load = ld; ifb.load_data = 4'(d);
            ifb.enable = en; ifb.up_down = ud; ifb.mode = 2'(md);
            ifa.clear = 1'b0; ifa.load = 1'b0; ifa.enable = 1'b0;
        end
        e.sel = sel; e.cnt = ec; e.tc = etc; e.dn = edn; e.nm = nm;
        sb.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (!e.sel) begin
                chk({e.nm, " count"},  int'(ifa.count), e.cnt);
                chk({e.nm, " is_max"}, int'(ifa.counter_is_max), int'(e.cnt == 10));
                chk({e.nm, " is_min"}, int'(ifa.counter_is_min), int'(e.cnt == 2));
                chk({e.nm, " tc"},     int'(ifa.tc_pulse), int'(e.tc));
                chk({e.nm, " done"},   int'(ifa.done), int'(e.dn));
            end else begin
                chk({e.nm, " count"},  int'(ifb.count), e.cnt);
                chk({e.nm, " tc"},     int'(ifb.tc_pulse), int'(e.tc));
                chk({e.nm, " done"},   int'(ifb.done), int'(e.dn));
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifa.clear = 0; ifa.load = 0; ifa.load_data = 0; ifa.enable = 0; ifa.up_down = 1; ifa.mode = 0;
        ifb.clear = 0; ifb.load = 0; ifb.load_data = 0; ifb.enable = 0; ifb.up_down = 1; ifb.mode = 0;

        tick(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, "reset_a");
        tick(1, 0, 0, 0, 0, 1, 0, 2, 0, 0, "reset_b");
        @(negedge clk);
        rst = 1'b0;

        // Wrap up across the window
        for (int v = 3; v <= 10; v++) tick(0, 0, 0, 0, 1, 1, 0, v, 0, 0, "wrap_up");
        tick(0, 0, 0, 0, 1, 1, 0, 2, 1, 0, "wrap_edge");
        tick(0, 0, 0, 0, 1, 1, 0, 3, 0, 0, "wrap_after");

        // Saturate down, clamped loads, load beating a boundary step
        tick(0, 0, 1, 3,  1, 0, 1, 3,  0, 0, "sat_load3");
        tick(0, 0, 0, 0,  1, 0, 1, 2,  0, 0, "sat_dn");
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1, 0, 1, 2, 1, 0, "sat_hold");
        tick(0, 0, 1, 15, 1, 0, 1, 10, 0, 0, "clamp_hi");
        tick(0, 0, 1, 0,  1, 0, 1, 2,  0, 0, "clamp_lo");
        tick(0, 0, 1, 2,  1, 0, 1, 2,  0, 0, "load_vs_step");
        tick(0, 0, 0, 0,  1, 0, 1, 2,  1, 0, "sat_hold2");

        // One-shot up: finish, freeze, reload
        tick(0, 0, 1, 8, 1, 1, 2, 8,  0, 0, "os_load8");
        tick(0, 0, 0, 0, 1, 1, 2, 9,  0, 0, "os_9");
        tick(0, 0, 0, 0, 1, 1, 2, 10, 0, 0, "os_10");
        tick(0, 0, 0, 0, 1, 1, 2, 10, 1, 1, "os_done");
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 1, 1, 2, 10, 0, 1, "os_frozen");
        tick(0, 0, 1, 5, 0, 1, 2, 5,  0, 0, "os_reload");
        tick(0, 0, 0, 0, 1, 1, 2, 6,  0, 0, "os_6");
        tick(0, 0, 0, 0, 1, 1, 2, 7,  0, 0, "os_7");

        // Clear beats load and step
        tick(0, 0, 1, 9, 1, 1, 0, 9, 0, 0, "pre_clear");
        tick(0, 1, 1, 5, 1, 1, 0, 2, 0, 0, "clear_all");
        tick(0, 0, 0, 0, 1, 1, 0, 3, 0, 0, "post_clear");

        // Prescale 3 with enable gaps mid-prescale
        tick(1, 0, 0, 0, 1, 1, 0, 2, 0, 0, "ps_e1");
        tick(1, 0, 0, 0, 1, 1, 0, 2, 0, 0, "ps_e2");
        tick(1, 0, 0, 0, 1, 1, 0, 3, 0, 0, "ps_step1");
        tick(1, 0, 0, 0, 1, 1, 0, 3, 0, 0, "ps_e4");
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0, 1, 0, 3, 0, 0, "ps_gap");
        tick(1, 0, 0, 0, 1, 1, 0, 3, 0, 0, "ps_e5");
        tick(1, 0, 0, 0, 1, 1, 0, 4, 0, 0, "ps_step2");
        tick(1, 0, 0, 0, 1, 1, 0, 4, 0, 0, "ps_e7");
        tick(1, 0, 0, 0, 1, 1, 0, 4, 0, 0, "ps_e8");
        tick(1, 1, 1, 6, 1, 1, 0, 2, 0, 0, "ps_clear");
        tick(1, 0, 0, 0, 1, 1, 0, 2, 0, 0, "ps_c1");
        tick(1, 0, 0, 0, 1, 1, 0, 2, 0, 0, "ps_c2");
        tick(1, 0, 0, 0, 1, 1, 0, 3, 0, 0, "ps_c3");
        tick(1, 0, 1, 10, 1, 1, 0, 10, 0, 0, "ps_load10");
        tick(1, 0, 0, 0,  1, 1, 0, 10, 0, 0, "ps_w1");
        tick(1, 0, 0, 0,  1, 1, 0, 10, 0, 0, "ps_w2");
        tick(1, 0, 0, 0,  1, 1, 0, 2,  1, 0, "ps_wrap");
        tick(1, 0, 0, 0,  1, 1, 0, 2,  0, 0, "ps_w4");
        tick(1, 0, 1, 10, 1, 1, 0, 10, 0, 0, "ps_reload");
        tick(1, 0, 0, 0,  1, 1, 0, 10, 0, 0, "ps_r1");
        tick(1, 0, 0, 0,  1, 1, 0, 10, 0, 0, "ps_r2");
        tick(1, 0, 1, 10, 1, 1, 0, 10, 0, 0, "ps_load_wins");
        tick(1, 0, 0, 0,  1, 1, 0, 10, 0, 0, "ps_l1");
        tick(1, 0, 0, 0,  1, 1, 0, 10, 0, 0, "ps_l2");
        tick(1, 0, 0, 0,  1, 1, 0, 2,  1, 0, "ps_l3");
        tick(1, 0, 1, 7,  0, 1, 0, 7,  0, 0, "ps_load7");

        // Async reset while A is done with tc high and B sits at 7
        tick(0, 0, 1, 9, 1, 1, 2, 9,  0, 0, "ar_load9");
        tick(0, 0, 0, 0, 1, 1, 2, 10, 0, 0, "ar_10");
        tick(0, 0, 0, 0, 1, 1, 2, 10, 1, 1, "ar_done");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst count_a",  int'(ifa.count), 2);
        chk("async_rst done_a",   int'(ifa.done), 0);
        chk("async_rst tc_a",     int'(ifa.tc_pulse), 0);
        chk("async_rst is_min_a", int'(ifa.counter_is_min), 1);
        chk("async_rst count_b",  int'(ifb.count), 2);
        @(negedge clk);
        rst = 1'b0;
        ifa.enable = 1'b0; ifa.load = 1'b0; ifa.clear = 1'b0;
        ifb.enable = 1'b0; ifb.load = 1'b0; ifb.clear = 1'b0;
        tick(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, "post_rst_idle");
        tick(0, 0, 0, 0, 1, 1, 0, 3, 0, 0, "post_rst_3");
        tick(0, 0, 0, 0, 1, 1, 0, 4, 0, 0, "post_rst_4");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
